// File: rtl/logic_exerciser_pkg.sv
// Shared types, sizes and golden function for the logic exerciser.
// The golden function describes the 4-in/2-out logic unit being exercised.
package logic_exerciser_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int ERR_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Returns {f1, f2}; vec bits map to a=vec[3], b=vec[2], c=vec[1], d=vec[0].
  function automatic logic [1:0] exp_outputs(input logic [VEC_W-1:0] vec);
    logic a, b, c, d;
    a = vec[3];
    b = vec[2];
    c = vec[1];
    d = vec[0];
    return {(a & b) | (c ^ d), (b | c) & ~d};
  endfunction

endpackage

// File: rtl/logic_exerciser_golden.sv
// Combinational reference for the logic unit, wrapping the package golden function.
module logic_golden_model
  import logic_exerciser_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             f1,
  output logic             f2
);

  always_comb begin
    {f1, f2} = exp_outputs(vec);
  end

endmodule

// File: rtl/logic_exerciser.sv
// Sweeps all 16 input vectors into the logic unit, samples its outputs after a
// settle delay and reports mismatch count, first failing vector and pass/fail.
module logic_exerciser
  import logic_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  output logic             dut_d,
  input  logic             dut_f1,
  input  logic             dut_f2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             first_err_valid_q, first_err_valid_d;
  logic [VEC_W-1:0] first_err_vec_q, first_err_vec_d;

  logic exp_f1, exp_f2;
  logic mismatch;

  logic_golden_model u_golden (
    .vec (vec_q),
    .f1  (exp_f1),
    .f2  (exp_f2)
  );

  // Either output differing counts the vector once.
  assign mismatch = (dut_f1 != exp_f1) || (dut_f2 != exp_f2);

  always_comb begin
    state_d           = state_q;
    vec_d             = vec_q;
    settle_cnt_d      = settle_cnt_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_vec_d   = first_err_vec_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d             = '0;
          settle_cnt_d      = '0;
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_vec_d   = '0;
          state_d           = SETTLE;
        end
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt_q + 4'd1;
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_count_q + 5'd1;
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_vec_d   = vec_q;
          end
        end
        if (vec_q == 4'(NUM_VEC - 1)) begin
          state_d = DONE;
        end else begin
          vec_d        = vec_q + 4'd1;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      vec_q             <= '0;
      settle_cnt_q      <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      settle_cnt_q      <= settle_cnt_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_vec_q   <= first_err_vec_d;
    end
  end

  assign {dut_a, dut_b, dut_c, dut_d} = vec_q;
  assign busy            = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_count_q == '0);
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;

endmodule

// File: tb/tb_logic_exerciser.sv
// Self-checking bench: a configurable faulty logic unit is looped back to the
// exerciser and results are compared with a reference computed from the truth table.
module tb_logic_exerciser;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic dut_a, dut_b, dut_c, dut_d, dut_f1, dut_f2;
  logic busy, done, pass, first_err_valid;
  logic [4:0] err_count;
  logic [3:0] first_err_vec;

  logic start1 = 1'b0;
  logic a1, b1, c1, d1, f1_1, f2_1;
  logic busy1, done1, pass1, fev1;
  logic [4:0] err1;
  logic [3:0] fvec1;

  int mode = 0;
  logic [15:0] m1 = '0, m2 = '0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  // Spec truth table of the unit, {f1,f2}.
  function automatic logic [1:0] ref_gold(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {(a & b) | (c ^ d), (b | c) & ~d};
  endfunction

  // Unit under exercise with injectable faults: 1=f2 stuck 0, 2=f1 inverted, 3=random flips.
  function automatic logic [1:0] unit_f(input logic [3:0] v, input int md,
                                        input logic [15:0] k1, input logic [15:0] k2);
    logic [1:0] f;
    f = ref_gold(v);
    case (md)
      1: f[0] = 1'b0;
      2: f[1] = ~f[1];
      3: f = f ^ {k1[v], k2[v]};
      default: ;
    endcase
    return f;
  endfunction

  assign {dut_f1, dut_f2} = unit_f({dut_a, dut_b, dut_c, dut_d}, mode, m1, m2);
  assign {f1_1, f2_1} = ref_gold({a1, b1, c1, d1});

  logic_exerciser #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d),
    .dut_f1(dut_f1), .dut_f2(dut_f2),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  logic_exerciser #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_d(d1),
    .dut_f1(f1_1), .dut_f2(f2_1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(fev1), .first_err_vec(fvec1)
  );

  function automatic logic [15:0] outs0();
    return {dut_a, dut_b, dut_c, dut_d, busy, done, pass, err_count, first_err_valid, first_err_vec};
  endfunction

  // Starts a sweep (start accepted at the next edge) and checks the full 48-cycle timeline
  // and the final results; mid_k >= 0 pulses start during the sweep.
  task automatic run_sweep(input string name, input int mid_k);
    int exp_err, exp_first, got_vec;
    exp_err = 0;
    exp_first = -1;
    for (int v = 0; v < 16; v++) begin
      if (unit_f(4'(v), mode, m1, m2) != ref_gold(4'(v))) begin
        exp_err++;
        if (exp_first < 0) exp_first = v;
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 48; k++) begin
      start = (k == mid_k);
      got_vec = int'({dut_a, dut_b, dut_c, dut_d});
      tests++;
      if (got_vec !== ((k < 48) ? k / 3 : 15) || busy !== (k < 48) || done !== (k == 48)) begin
        fails++;
        $display("FAIL %s timeline k=%0d: vec=%0d busy=%b done=%b, want vec=%0d busy=%b done=%b",
                 name, k, got_vec, busy, done, (k < 48) ? k / 3 : 15, k < 48, k == 48);
      end
      if (k == 0) begin
        tests++;
        if (err_count !== 5'd0 || first_err_valid !== 1'b0 || first_err_vec !== 4'd0) begin
          fails++;
          $display("FAIL %s clear: err=%0d fev=%b fvec=%0d, want 0/0/0",
                   name, err_count, first_err_valid, first_err_vec);
        end
      end
      if (k < 48) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    tests++;
    if (err_count !== 5'(exp_err) || pass !== (exp_err == 0) ||
        first_err_valid !== (exp_err != 0) ||
        first_err_vec !== ((exp_first < 0) ? 4'd0 : 4'(exp_first))) begin
      fails++;
      $display("FAIL %s result: err=%0d pass=%b fev=%b fvec=%0d, want err=%0d pass=%b fev=%b fvec=%0d",
               name, err_count, pass, first_err_valid, first_err_vec, exp_err,
               exp_err == 0, exp_err != 0, (exp_first < 0) ? 0 : exp_first);
    end
    $display("[TB] %s: mode=%0d err=%0d first=%0d", name, mode, exp_err, exp_first);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (outs0() !== 16'd0 || {a1, b1, c1, d1, busy1, done1, pass1, err1, fev1, fvec1} !== 16'd0) begin
      fails++;
      $display("FAIL reset outputs: got %h, want 0", outs0());
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset idle: busy=%b done=%b, want 0/0", busy, done);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_loopback();
    mode = 0;
    run_sweep("loopback", -1);
  endtask

  task automatic test_f2_stuck();
    mode = 1;
    run_sweep("f2_stuck", -1);
    tests++;
    if (err_count !== 5'd6 || first_err_vec !== 4'b0010 || pass !== 1'b0) begin
      fails++;
      $display("FAIL f2_stuck const: err=%0d fvec=%0d pass=%b, want 6/2/0", err_count, first_err_vec, pass);
    end
  endtask

  task automatic test_f1_inverted();
    mode = 2;
    run_sweep("f1_inv", -1);
    tests++;
    if (err_count !== 5'd16 || first_err_vec !== 4'd0 || first_err_valid !== 1'b1) begin
      fails++;
      $display("FAIL f1_inv const: err=%0d fvec=%0d fev=%b, want 16/0/1", err_count, first_err_vec, first_err_valid);
    end
  endtask

  task automatic test_done_hold();
    logic [15:0] snap;
    snap = outs0();
    mode = 0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (outs0() !== snap) begin
      fails++;
      $display("FAIL done_hold: got %h, want %h", outs0(), snap);
    end
    $display("[TB] done_hold checked");
  endtask

  task automatic test_back_to_back();
    mode = 1;
    run_sweep("b2b_first", -1);
    mode = 3;
    m1 = 16'($urandom);
    m2 = 16'($urandom);
    run_sweep("b2b_second", -1);
  endtask

  task automatic test_mid_start();
    mode = 3;
    m1 = 16'($urandom) & 16'hF0F0;
    m2 = 16'($urandom) & 16'h0FF0;
    run_sweep("mid_start", 20);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      mode = 3;
      m1 = 16'($urandom);
      m2 = (i == 3) ? 16'd0 : 16'($urandom);
      if (i == 3) m1 = 16'h8000;
      run_sweep($sformatf("random%0d", i), -1);
    end
  endtask

  task automatic test_reset_mid();
    mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    tests++;
    if ({dut_a, dut_b, dut_c, dut_d} !== 4'd7 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid pre: vec=%0d busy=%b, want 7/1", {dut_a, dut_b, dut_c, dut_d}, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (outs0() !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid async: got %h, want 0", outs0());
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 2;
    run_sweep("after_reset", -1);
  endtask

  task automatic test_settle1();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      tests++;
      if (int'({a1, b1, c1, d1}) !== ((k < 32) ? k / 2 : 15) || done1 !== (k == 32)) begin
        fails++;
        $display("FAIL settle1 k=%0d: vec=%0d done=%b, want vec=%0d done=%b",
                 k, {a1, b1, c1, d1}, done1, (k < 32) ? k / 2 : 15, k == 32);
      end
      if (k < 32) begin
        @(posedge clk); #1;
      end
    end
    tests++;
    if (pass1 !== 1'b1 || err1 !== 5'd0 || fev1 !== 1'b0) begin
      fails++;
      $display("FAIL settle1 result: pass=%b err=%0d fev=%b, want 1/0/0", pass1, err1, fev1);
    end
    $display("[TB] settle1 checked");
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_f2_stuck();
    test_f1_inverted();
    test_done_hold();
    test_back_to_back();
    test_mid_start();
    test_random();
    test_reset_mid();
    test_settle1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_exerciser.md
# logic_exerciser

Sequential stimulus/checker that drives the other end of the team's 4-input/2-output combinational logic unit (inputs A..D, outputs F1/F2). On a start pulse it sweeps all 16 input vectors and samples the unit's outputs after a settle delay. Each sample is compared against a golden model, and the block counts mismatches, records the first failing vector and reports pass/fail through a start/busy/done handshake. It sits beside the logic unit in lab builds and self-test wrappers.

## Interface
- SETTLE_CYCLES, default 2: cycles each vector is held before sampling; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- dut_a, dut_b, dut_c, dut_d  out  1 each  registered stimulus: a=vec[3], b=vec[2], c=vec[1], d=vec[0].
- dut_f1, dut_f2  in  1 each  unit outputs, synchronous to clk.
- busy  out  1  high in SETTLE and SAMPLE.
- done  out  1  high in DONE; held until the next accepted start or reset.
- pass  out  1  equals done AND (err_count == 0).
- err_count  out  5  mismatching vectors in the current or last sweep, 0..16.
- first_err_valid  out  1  at least one mismatch is recorded.
- first_err_vec  out  4  vector index of the first mismatch; 0 when none.

## Operation
- Golden model:
  - exp_f1 = (a & b) | (c ^ d)
  - exp_f2 = (b | c) & ~d
- A vector mismatches if either output differs; it counts once even if both differ.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE with start=1:
  - vec<=0, settle_cnt<=0, err_count<=0, first_err_valid<=0, first_err_vec<=0.
  - Next state SETTLE.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt == SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - Compare dut_f1/dut_f2 with the golden model of vec.
  - On mismatch: err_count increments; if first_err_valid=0, capture vec and set first_err_valid.
  - If vec == 15, go to DONE.
  - Otherwise vec<=vec+1, settle_cnt<=0, go to SETTLE.
- DONE: all results frozen. dut_* keep the last vector (1111).
- start in SETTLE or SAMPLE is ignored, with no effect on counters.
- err_count cannot overflow: 5 bits hold 16. No saturation logic.
- dut_* come straight from the vec register; no combinational path from any input to any output.

## Timing
- Reset value of every output is 0: dut_*, busy, done, pass, err_count, first_err_valid, first_err_vec. State resets to IDLE.
- Reset mid-sweep aborts immediately and asynchronously. A later start runs a full fresh sweep.
- start is sampled at edge 0; busy is high after edge 0.
- Each vector is held SETTLE_CYCLES+1 cycles and sampled in its last cycle.
- done rises after edge 16*(SETTLE_CYCLES+1). That is edge 48 at the default, when busy also falls.
- Back-to-back: start asserted in the first DONE cycle is accepted. done drops after that edge and the new sweep begins with vec=0.
- The unit under test must settle within SETTLE_CYCLES cycles of a dut_* change.

## Structure
- Shared package logic_exerciser_pkg holds:
  - state enum: IDLE, SETTLE, SAMPLE, DONE
  - VEC_W=4, NUM_VEC=16, ERR_W=5
  - golden function exp_outputs(vec) returning {f1,f2}
- One natural sub-module: logic_golden_model, a combinational 4-in/2-out reference wrapping the package function. It is instanced once and reusable by the testbench scoreboard.

## Test plan
- Bench uses SETTLE_CYCLES=2 unless stated.
- Loopback to a correct unit, start pulse:
  - done after 48 cycles.
  - pass=1, err_count=0, first_err_valid=0.
- dut_f2 stuck at 0:
  - Mismatches on vectors 2, 4, 6, 10, 12, 14.
  - err_count=6, first_err_vec=4'b0010, pass=0.
- dut_f1 inverted:
  - err_count=16, first_err_vec=0, first_err_valid=1.
- Stimulus order:
  - dut_{a,b,c,d} step 0000..1111, each value held exactly 3 cycles.
  - With SETTLE_CYCLES=1: each value held 2 cycles, done at cycle 32.
- Handshake:
  - start pulsed mid-sweep has no effect.
  - start in DONE clears done, err_count and first_err_valid, then reruns the sweep.
- Reset:
  - rst_n low while vec=7: all outputs go to 0 without a clock edge.
  - After release, start gives a full 48-cycle sweep with correct counts.
